kbd_seg_ctrl: RTL and testbench

KBD_SEG_CTRL -- requirements
Module: kbd_seg_ctrl

---
 rtl/kbd_seg_ctrl.sv | 170 +++++++++++++++++
 tb/tb_kbd_seg_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_seg_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_seg_ctrl
//
// Purpose:
//   Drains a PS/2 keyboard receive FIFO one byte at a time, decodes make and
//   break (F0-prefixed) scan codes, remembers the last pressed key and keeps
//   a two-digit BCD count of distinct key presses suitable for a 7-segment
//   display. A sticky error flag records FIFO overflow.
//
// Ports:
//   clk          - single clock, all state updates on rising edge
//   rst          - asynchronous active-high reset
//   kbd_data     - head byte of the receive FIFO, valid while kbd_ready
//   kbd_ready    - FIFO non-empty
//   kbd_overflow - FIFO overflow indication (sets err)
//   clr          - synchronous clear of count and err
//   kbd_pop      - one-cycle pulse popping the FIFO head
//   last_code    - last accepted make code
//   key_held     - key of last_code currently pressed
//   cnt_ones     - BCD ones digit of key-press count
//   cnt_tens     - BCD tens digit of key-press count
//   err          - sticky overflow flag
//   ext_key      - (KBD_EXT_CODE_EN only) last make was E0-extended
//
// Configuration:
//   KBD_EXT_CODE_EN - when defined, 0xE0 prefixes are decoded through an EXT
//                     state and the ext_key output is present. When
//                     undefined, 0xE0 is popped and silently discarded.
// ---------------------------------------------------------------------------
module kbd_seg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  input  logic       clr,
  output logic       kbd_pop,
  output logic [7:0] last_code,
  output logic       key_held,
  output logic [3:0] cnt_ones,
  output logic [3:0] cnt_tens,
`ifdef KBD_EXT_CODE_EN
  output logic       ext_key,
`endif
  output logic       err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;
`ifdef KBD_EXT_CODE_EN
  localparam logic [1:0] ST_EXT  = 2'd3;
`endif

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;

  logic [1:0] r_state;
  logic [1:0] r_resume;
  logic [7:0] r_lastCode;
  logic       r_keyHeld;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic       r_err;
`ifdef KBD_EXT_CODE_EN
  logic       r_extKey;
  logic       r_brkExt;
  logic       w_makeExt;
`endif

  logic w_pop;
  logic w_inBrk;
  logic w_repeat;
  logic w_breakMatch;
  logic w_make;

  // IDLE, BRK and EXT all sample the FIFO; WAIT is the mandatory gap after
  // every pop. The prefix seen so far is parked in r_resume across WAIT.
  assign w_pop   = (r_state != ST_WAIT) && kbd_ready && !rst;
  assign w_inBrk = (r_state == ST_BRK);

`ifdef KBD_EXT_CODE_EN
  // Extended codes only match when both the byte and the E0 qualifier agree.
  assign w_makeExt    = (r_state == ST_EXT);
  assign w_repeat     = r_keyHeld && (kbd_data == r_lastCode) && (r_extKey == w_makeExt);
  assign w_breakMatch = (kbd_data == r_lastCode) && (r_extKey == r_brkExt);
`else
  assign w_repeat     = r_keyHeld && (kbd_data == r_lastCode);
  assign w_breakMatch = (kbd_data == r_lastCode);
`endif

  // A new key press: popped outside BRK, not a prefix byte, not auto-repeat.
  assign w_make = w_pop && !w_inBrk && (kbd_data != BYTE_BREAK) &&
                  (kbd_data != BYTE_EXT) && !w_repeat;

  // Decode FSM plus last-code tracking; outputs change on the pop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_resume   <= ST_IDLE;
      r_lastCode <= 8'h00;
      r_keyHeld  <= 1'b0;
`ifdef KBD_EXT_CODE_EN
      r_extKey   <= 1'b0;
      r_brkExt   <= 1'b0;
`endif
    end else if (r_state == ST_WAIT) begin
      r_state <= r_resume;
    end else if (w_pop) begin
      r_state  <= ST_WAIT;
      r_resume <= ST_IDLE;
      if (w_inBrk) begin
        if (w_breakMatch) begin
          r_keyHeld <= 1'b0;
        end
      end else if (kbd_data == BYTE_BREAK) begin
        r_resume <= ST_BRK;
`ifdef KBD_EXT_CODE_EN
        r_brkExt <= w_makeExt;
`endif
`ifdef KBD_EXT_CODE_EN
      end else if (kbd_data == BYTE_EXT) begin
        r_resume <= ST_EXT;
`endif
      end else if (w_make) begin
        r_lastCode <= kbd_data;
        r_keyHeld  <= 1'b1;
`ifdef KBD_EXT_CODE_EN
        r_extKey   <= w_makeExt;
`endif
      end
    end
  end

  // BCD press counter and sticky error; clr wins over increment and overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_err  <= 1'b0;
    end else if (clr) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_err  <= 1'b0;
    end else begin
      if (kbd_overflow) begin
        r_err <= 1'b1;
      end
      if (w_make) begin
        if (r_ones == 4'd9) begin
          r_ones <= 4'd0;
          r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end else begin
          r_ones <= r_ones + 4'd1;
        end
      end
    end
  end

  assign kbd_pop   = w_pop;
  assign last_code = r_lastCode;
  assign key_held  = r_keyHeld;
  assign cnt_ones  = r_ones;
  assign cnt_tens  = r_tens;
  assign err       = r_err;
`ifdef KBD_EXT_CODE_EN
  assign ext_key   = r_extKey;
`endif

endmodule

// File: tb/tb_kbd_seg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kbd_seg_ctrl
//
// Purpose:
//   Self-checking bench for kbd_seg_ctrl. A table of scan-code bytes with
//   hand-computed expected outputs is applied in a loop, followed by
//   hand-written sequences for overflow/clear, BCD wrap, back-to-back
//   throughput and reset in the middle of a break sequence.
//   Define KBD_EXT_CODE_EN to also exercise the ext_key output.
// ---------------------------------------------------------------------------
module tb_kbd_seg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       clr;
  logic       kbd_pop;
  logic [7:0] last_code;
  logic       key_held;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;
  logic       err;
`ifdef KBD_EXT_CODE_EN
  logic       ext_key;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] lc;
    logic       held;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[10];

  kbd_seg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .kbd_data     (kbd_data),
    .kbd_ready    (kbd_ready),
    .kbd_overflow (kbd_overflow),
    .clr          (clr),
    .kbd_pop      (kbd_pop),
    .last_code    (last_code),
    .key_held     (key_held),
    .cnt_ones     (cnt_ones),
    .cnt_tens     (cnt_tens),
`ifdef KBD_EXT_CODE_EN
    .ext_key      (ext_key),
`endif
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  // Present one byte, wait (bounded) for the pop, then let the WAIT cycle pass.
  // Called and returns at posedge+1.
  task automatic applyStimulus(input logic [7:0] data);
    bit got;
    got       = 1'b0;
    kbd_data  = data;
    kbd_ready = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (kbd_pop) got = 1'b1;
      @(posedge clk);
      #1;
    end
    kbd_ready = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL pop_timeout: got no pop, expected pop for byte 0x%02h", data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prevPop;
    int   pops;
    int   doubles;

    vecs[0] = '{8'h1C, 8'h1C, 1'b1, 8'h01};
    vecs[1] = '{8'h1C, 8'h1C, 1'b1, 8'h01};
    vecs[2] = '{8'h1C, 8'h1C, 1'b1, 8'h01};
    vecs[3] = '{8'hF0, 8'h1C, 1'b1, 8'h01};
    vecs[4] = '{8'h1C, 8'h1C, 1'b0, 8'h01};
    vecs[5] = '{8'h1C, 8'h1C, 1'b1, 8'h02};
    vecs[6] = '{8'hF0, 8'h1C, 1'b1, 8'h02};
    vecs[7] = '{8'h2B, 8'h1C, 1'b1, 8'h02};
    vecs[8] = '{8'hE0, 8'h1C, 1'b1, 8'h02};
    vecs[9] = '{8'h75, 8'h75, 1'b1, 8'h03};

    // Reset with the FIFO claiming data: no pop, all outputs cleared.
    rst          = 1'b1;
    kbd_data     = 8'h1C;
    kbd_ready    = 1'b1;
    kbd_overflow = 1'b0;
    clr          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pop", {7'd0, kbd_pop}, 8'h00);
    checkOutput("rst_last_code", last_code, 8'h00);
    checkOutput("rst_key_held", {7'd0, key_held}, 8'h00);
    checkOutput("rst_count", {cnt_tens, cnt_ones}, 8'h00);
    checkOutput("rst_err", {7'd0, err}, 8'h00);
    @(posedge clk);
    #1;
    kbd_ready = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;

    // Table of single bytes with expected outputs after each.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("vec%0d_last_code", i), last_code, vecs[i].lc);
      checkOutput($sformatf("vec%0d_key_held", i), {7'd0, key_held}, {7'd0, vecs[i].held});
      checkOutput($sformatf("vec%0d_count", i), {cnt_tens, cnt_ones}, vecs[i].cnt);
    end
`ifdef KBD_EXT_CODE_EN
    checkOutput("ext_key_after_e0_75", {7'd0, ext_key}, 8'h01);
`endif

    // One-cycle overflow pulse sets a sticky error.
    kbd_overflow = 1'b1;
    @(posedge clk);
    #1;
    kbd_overflow = 1'b0;
    checkOutput("err_set", {7'd0, err}, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_sticky", {7'd0, err}, 8'h01);

    // clr during a make: count and err cleared, code still captured.
    clr = 1'b1;
    applyStimulus(8'h2B);
    clr = 1'b0;
    checkOutput("clr_count", {cnt_tens, cnt_ones}, 8'h00);
    checkOutput("clr_err", {7'd0, err}, 8'h00);
    checkOutput("clr_last_code", last_code, 8'h2B);
    checkOutput("clr_key_held", {7'd0, key_held}, 8'h01);

    // clr beats a simultaneous overflow.
    kbd_overflow = 1'b1;
    clr          = 1'b1;
    @(posedge clk);
    #1;
    kbd_overflow = 1'b0;
    clr          = 1'b0;
    checkOutput("clr_vs_overflow", {7'd0, err}, 8'h00);

    // 99 make/break pairs, then one more make wraps 99 -> 00.
    for (int i = 0; i < 99; i++) begin
      applyStimulus(8'h10 + 8'(i));
      applyStimulus(8'hF0);
      applyStimulus(8'h10 + 8'(i));
    end
    checkOutput("preload_count", {cnt_tens, cnt_ones}, 8'h99);
    checkOutput("preload_key_held", {7'd0, key_held}, 8'h00);
    applyStimulus(8'h32);
    checkOutput("wrap_count", {cnt_tens, cnt_ones}, 8'h00);
    checkOutput("wrap_last_code", last_code, 8'h32);

    // kbd_ready held high: pop every second cycle, never back to back.
    kbd_data  = 8'h33;
    kbd_ready = 1'b1;
    prevPop   = 1'b0;
    pops      = 0;
    doubles   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (kbd_pop) pops++;
      if (kbd_pop && prevPop) doubles++;
      prevPop = kbd_pop;
      @(posedge clk);
      #1;
    end
    kbd_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stream_pops", 8'(pops), 8'd10);
    checkOutput("stream_back_to_back", 8'(doubles), 8'd0);
    checkOutput("stream_count", {cnt_tens, cnt_ones}, 8'h01);
    checkOutput("stream_last_code", last_code, 8'h33);

    // Reset while a break prefix is pending: prefix must be forgotten.
    applyStimulus(8'hF0);
    rst       = 1'b1;
    kbd_ready = 1'b1;
    kbd_data  = 8'h33;
    #1;
    checkOutput("async_rst_last_code", last_code, 8'h00);
    checkOutput("async_rst_count", {cnt_tens, cnt_ones}, 8'h00);
    checkOutput("async_rst_pop", {7'd0, kbd_pop}, 8'h00);
    @(posedge clk);
    #1;
    kbd_ready = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'h33);
    checkOutput("post_rst_last_code", last_code, 8'h33);
    checkOutput("post_rst_key_held", {7'd0, key_held}, 8'h01);
    checkOutput("post_rst_count", {cnt_tens, cnt_ones}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
